// File: rtl/return_addr_stack.sv
// Return-address stack for the IF stage. A call pushes the link address
// (call PC + 8, past the delay slot). A return reads the top entry as its
// predicted target and pops it. When the stack is full, a push overwrites
// the oldest entry. A push and a pop in the same cycle replace the top
// entry. A flush discards everything on a pipeline redirect.
//
// There is no valid/ready handshake: push, pop and flush are single-cycle
// qualifiers sampled on every rising clk edge, and the stack never stalls.
// All outputs are functions of registered state only.
module return_addr_stack #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic        pop,
    input  logic        flush,
    output logic [31:0] top_addr,
    output logic        top_valid,
    output logic        full,
    output logic        overflow
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] tos, tos_nx;
    logic [PTR_W:0]   count, count_nx;
    logic             ovf_q, ovf_nx;
    logic             we;
    logic [PTR_W-1:0] waddr;
    logic [31:0]      link;

    // The link address wraps modulo 2^32 and is not checked for alignment.
    assign link = push_pc + 32'h8;

    // Next-state decode. Priority is flush, then replace, then push, then pop.
    always_comb begin
        tos_nx   = tos;
        count_nx = count;
        ovf_nx   = 1'b0;
        we       = 1'b0;
        waddr    = tos;
        if (flush) begin
            tos_nx   = '0;
            count_nx = '0;
        end else if (push && pop && (count != '0)) begin
            // Replace the top entry. Pointer and depth stay the same.
            we    = 1'b1;
            waddr = tos;
        end else if (push) begin
            // An empty replace lands here too and acts as a plain push.
            tos_nx = tos + PTR_ONE;
            we     = 1'b1;
            waddr  = tos + PTR_ONE;
            if (count == DEPTH_C) begin
                // Circular buffer: the new top slot holds the oldest entry.
                ovf_nx = 1'b1;
            end else begin
                count_nx = count + CNT_ONE;
            end
        end else if (pop && (count != '0)) begin
            tos_nx   = tos - PTR_ONE;
            count_nx = count - CNT_ONE;
        end
    end

    // Control state, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos   <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            tos   <= tos_nx;
            count <= count_nx;
            ovf_q <= ovf_nx;
        end
    end

    // Entry storage. It has no reset because empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= link;
        end
    end

    assign top_valid = (count != '0);
    assign full      = (count == DEPTH_C);
    assign overflow  = ovf_q;
    assign top_addr  = top_valid ? mem[tos] : 32'h0;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack. Each step drives one cycle of
// push/pop/flush and updates an unbounded queue-based reference model of the
// stack. The model's expected outputs are pushed into exp_q. After the clock
// edge the expected outputs are popped and compared with the DUT.
module tb_return_addr_stack;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic [31:0] push_pc;
    logic        pop;
    logic        flush;
    logic [31:0] top_addr;
    logic        top_valid;
    logic        full;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Expected outputs packed as {top_addr, top_valid, full, overflow}.
    logic [34:0] exp_q [$];

    // Reference model: a list of link addresses, with the oldest entry at the front.
    logic [31:0] m_q [$];
    logic        m_ovf;

    return_addr_stack #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_pc   (push_pc),
        .pop       (pop),
        .flush     (flush),
        .top_addr  (top_addr),
        .top_valid (top_valid),
        .full      (full),
        .overflow  (overflow)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: stops the run if the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge and queue the resulting outputs.
    task automatic model_step(input logic p, input logic [31:0] pc, input logic o, input logic f);
        logic [31:0] t;
        m_ovf = 1'b0;
        if (f) begin
            m_q.delete();
        end else if (p && o && m_q.size() > 0) begin
            m_q[m_q.size()-1] = pc + 32'h8;
        end else if (p) begin
            if (m_q.size() == DEPTH) begin
                t = m_q.pop_front();
                m_ovf = 1'b1;
            end
            m_q.push_back(pc + 32'h8);
        end else if (o && m_q.size() > 0) begin
            t = m_q.pop_back();
        end
        t = (m_q.size() > 0) ? m_q[m_q.size()-1] : 32'h0;
        exp_q.push_back({t, m_q.size() != 0, m_q.size() == DEPTH, m_ovf});
    endtask

    // Drive one cycle. The check happens 1 time unit after the rising edge.
    task automatic cycle(input logic p, input logic [31:0] pc, input logic o, input logic f,
                         input string tag);
        logic [34:0] e;
        @(negedge clk);
        push = p; push_pc = pc; pop = o; flush = f;
        model_step(p, pc, o, f);
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_top"},   top_addr,          e[34:3]);
            check({tag, "_valid"}, 32'(top_valid),    32'(e[2]));
            check({tag, "_full"},  32'(full),         32'(e[1]));
            check({tag, "_ovf"},   32'(overflow),     32'(e[0]));
        end
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_top"},   top_addr,       32'h0);
        check({tag, "_valid"}, 32'(top_valid), 32'h0);
        check({tag, "_full"},  32'(full),      32'h0);
        check({tag, "_ovf"},   32'(overflow),  32'h0);
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; push_pc = 32'h0; pop = 1'b0; flush = 1'b0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        @(negedge clk) rst_n = 1'b1;

        // Basic LIFO, including a pop from the empty stack.
        cycle(1, 32'h0040_0010, 0, 0, "lifo_push1");
        check("lifo_lit1", top_addr, 32'h0040_0018);
        cycle(1, 32'h0040_0100, 0, 0, "lifo_push2");
        check("lifo_lit2", top_addr, 32'h0040_0108);
        cycle(0, 32'h0, 1, 0, "lifo_pop1");
        check("lifo_lit3", top_addr, 32'h0040_0018);
        cycle(0, 32'h0, 1, 0, "lifo_pop2");
        cycle(0, 32'h0, 1, 0, "lifo_pop_empty");
        check_zero("lifo_empty");

        // Overflow: fill the stack, overwrite the oldest entry, then drain it.
        for (int k = 0; k < DEPTH; k++) cycle(1, 32'h1000 + 32'(16*k), 0, 0, "fill");
        check("fill_full", 32'(full), 32'h1);
        check("fill_top", top_addr, 32'h1078);
        cycle(1, 32'h2000, 0, 0, "ovf_push");
        check("ovf_pulse", 32'(overflow), 32'h1);
        check("ovf_top", top_addr, 32'h2008);
        for (int k = 0; k < DEPTH; k++) cycle(0, 32'h0, 1, 0, "drain");
        check("drain_valid", 32'(top_valid), 32'h0);

        // Two overflowing pushes in a row keep overflow high, then it drops.
        for (int k = 0; k < DEPTH; k++) cycle(1, 32'h3000 + 32'(4*k), 0, 0, "refill");
        cycle(1, 32'h4000, 0, 0, "ovf_b2b1");
        cycle(1, 32'h4100, 0, 0, "ovf_b2b2");
        check("ovf_b2b_hold", 32'(overflow), 32'h1);
        cycle(0, 32'h0, 0, 0, "ovf_idle");
        check("ovf_cleared", 32'(overflow), 32'h0);
        cycle(0, 32'h0, 0, 1, "ovf_flush");

        // Replace: pushing and popping in the same cycle rewrites the top.
        cycle(1, 32'h0000_00F8, 0, 0, "rep_a");
        cycle(1, 32'h0000_0200, 0, 0, "rep_b");
        cycle(1, 32'h0000_0300, 1, 0, "rep_swap");
        check("rep_lit", top_addr, 32'h308);
        cycle(0, 32'h0, 1, 0, "rep_pop");
        check("rep_pop_lit", top_addr, 32'h100);
        cycle(0, 32'h0, 1, 0, "rep_pop2");
        cycle(1, 32'h0000_0040, 1, 0, "rep_empty");
        check("rep_empty_lit", top_addr, 32'h48);

        // The link address wraps modulo 2^32.
        cycle(1, 32'hFFFF_FFFC, 0, 0, "wrap");
        check("wrap_lit", top_addr, 32'h0000_0004);

        // Flush wins over a simultaneous push and pop.
        cycle(1, 32'h0000_0600, 0, 0, "fl_fill");
        cycle(1, 32'h0000_0700, 1, 1, "fl_flush");
        check_zero("fl_after");
        cycle(1, 32'h0000_0500, 0, 0, "fl_push");
        check("fl_push_lit", top_addr, 32'h508);
        cycle(0, 32'h0, 1, 0, "fl_pop");

        // Random mix of operations, including overflow and replace cases.
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hFFFF)) << 2,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), "rnd");

        // An asynchronous reset mid-cycle, held with push active.
        cycle(1, 32'h0000_0800, 0, 0, "rst_pre");
        @(posedge clk);
        #2;
        rst_n = 1'b0; push = 1'b1; push_pc = 32'h0000_0900;
        #1;
        check_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        m_q.delete();
        @(negedge clk);
        rst_n = 1'b1; push = 1'b0;
        cycle(1, 32'h0000_0A00, 0, 0, "rst_after");
        check("rst_after_lit", top_addr, 32'h0A08);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Return-address stack for the IF stage of the 5-stage MIPS pipeline: the consumer side of the link-address path. On a decoded call (jal/jalr) it captures the call PC, forms the link address PC+8 (the address past the delay slot), and pushes it. On a decoded return (jr $ra) it supplies the predicted target from the top of stack and pops it. It is a circular LIFO with overflow-overwrite, same-cycle replace, and flush for pipeline redirects.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2; PTR_W = log2(DEPTH)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  call decoded this cycle; store push_pc+8
- push_pc  in  32  address of the call instruction
- pop  in  1  return decoded this cycle; consume top entry
- flush  in  1  discard all entries (mispredict/exception redirect)
- top_addr  out  32  predicted return target = top entry; 0 when empty
- top_valid  out  1  stack non-empty (count != 0)
- full  out  1  count == DEPTH
- overflow  out  1  one-cycle registered pulse: the previous cycle's push overwrote the oldest entry

## Operation
- State: mem[DEPTH] of 32 bits, tos pointer (PTR_W), count (0..DEPTH, PTR_W+1 bits), overflow register.
- Link arithmetic: stored value = push_pc + 32'h8, modulo 2^32. 0xFFFFFFFC becomes 0x00000004. No alignment check.
- Priority per clock edge: flush > (push & pop) > push > pop.
- flush: count←0, tos←0, overflow←0. Push/pop in the same cycle are ignored. mem is not cleared.
- push only: tos←tos+1 mod DEPTH, mem[tos+1]←push_pc+8, count←min(count+1, DEPTH). If count==DEPTH beforehand, the oldest entry is overwritten, count stays DEPTH, and overflow←1.
- pop only: if count>0, tos←tos−1 mod DEPTH and count←count−1. If count==0, there is no state change. This is not an error.
- push & pop with count>0: replace top, mem[tos]←push_pc+8. tos and count are unchanged, and no overflow.
- push & pop with count==0: behaves exactly as push only.
- overflow←0 on every edge that does not set it.
- top_addr = count!=0 ? mem[tos] : 32'h0. This is combinational from state, with no input-to-output path.

## Timing
- Reset (rst_n low, asynchronous, takes effect without clk): tos=0, count=0, overflow=0. Hence top_addr=0, top_valid=0, full=0, overflow=0. mem contents are don't-care, because top_addr is masked.
- Reset deasserted mid-operation discards all entries. The first edge after release obeys the normal rules.
- Latency: push/pop/flush at edge N are visible on top_addr/top_valid/full after edge N (1 cycle). A return consuming top_addr in cycle N sees the state from before that cycle's push/pop.
- overflow is high for exactly the cycle after the overflowing edge. Back-to-back overflowing pushes hold it high continuously.
- All outputs change only on clk rising edge or rst_n falling edge.

## Test plan
- Reset: assert rst_n=0 between clock edges. top_addr=0, top_valid=0, full=0, overflow=0 immediately. Hold across clocks with push=1: no change.
- Basic LIFO: push 0x00400010, then push 0x00400100. top_addr reads 0x00400018, then 0x00400108. pop → 0x00400018. pop → top_valid=0, top_addr=0. Extra pop → no change.
- Overflow (DEPTH=8): push 0x1000+16k for k=0..7 → full=1, top 0x1078. Push 0x2000 → overflow=1 for one cycle, full stays 1, top 0x2008. Eight pops return 0x2008, 0x1078 … 0x1018 (0x1008 lost), then top_valid=0.
- Replace: with entries {0x100, 0x208}, push&pop with push_pc=0x300 → top 0x308, count 2. pop → 0x100. With empty stack, push&pop with 0x40 → top 0x48, top_valid=1.
- Wrap arithmetic: push 0xFFFFFFFC → top_addr 0x00000004.
- Flush: 3 entries, flush with push=1 and pop=1 → top_valid=0, overflow=0. Next push 0x500 → top 0x508, count 1.
